lcd_result_writer: RTL and testbench

- Sequencer that turns a calculator result into one complete LCD line and pushes it into the display driver's 32-entry write FIFO.
- Accepts a signed 16-bit value, or an error flag, on a START pulse.
- Converts the value to decimal ASCII serially, one subtraction per cycle.
- Emits one cursor-address command followed by exactly 16 right-aligned character entries on the driver's WR_EN / 9-bit DATA_IN interface: bit 8 = RS, bits 7:0 = byte.

---
 rtl/lcd_result_writer.sv | 216 +++++++++++++++++++++
 tb/tb_lcd_result_writer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_result_writer.sv
// Converts a signed 16-bit result (or an error flag) into one right-aligned 16-character
// LCD line and streams it, preceded by a cursor-address command, into the driver write FIFO.
module lcd_result_writer #(
  parameter int GAP_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        START,
  input  logic [15:0] VALUE,
  input  logic        LINE,
  input  logic        ERR,
  output logic        WR_EN,
  output logic [8:0]  DATA_OUT,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [15:0] GAP = 16'(GAP_CYCLES);

  typedef enum logic [2:0] {IDLE, ABS, CONV, CMD, PAD, SIGN, DIGIT, FIN} state_t;

  state_t          state_q, state_d;
  logic            line_q, line_d;
  logic            err_q, err_d;
  logic            neg_q, neg_d;
  logic [15:0]     rem_q, rem_d;
  logic [3:0]      cur_q, cur_d;
  logic [2:0]      pidx_q, pidx_d;
  logic            started_q, started_d;
  logic [2:0]      first_q, first_d;
  logic [4:0][3:0] digits_q, digits_d;
  logic [3:0]      pad_q, pad_d;
  logic [2:0]      didx_q, didx_d;
  logic [15:0]     gap_q, gap_d;
  logic            wr_q, wr_d;
  logic [8:0]      data_q, data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  function automatic logic [15:0] placeVal(input logic [2:0] idx);
    case (idx)
      3'd0:    placeVal = 16'd10000;
      3'd1:    placeVal = 16'd1000;
      3'd2:    placeVal = 16'd100;
      3'd3:    placeVal = 16'd10;
      default: placeVal = 16'd1;
    endcase
  endfunction

  function automatic logic [7:0] errChar(input logic [2:0] idx);
    case (idx)
      3'd0:    errChar = 8'h45;
      3'd3:    errChar = 8'h4F;
      default: errChar = 8'h52;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= IDLE;
      line_q    <= 1'b0;
      err_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_q     <= 16'd0;
      cur_q     <= 4'd0;
      pidx_q    <= 3'd0;
      started_q <= 1'b0;
      first_q   <= 3'd0;
      digits_q  <= '0;
      pad_q     <= 4'd0;
      didx_q    <= 3'd0;
      gap_q     <= 16'd0;
      wr_q      <= 1'b0;
      data_q    <= 9'h000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      err_q     <= err_d;
      neg_q     <= neg_d;
      rem_q     <= rem_d;
      cur_q     <= cur_d;
      pidx_q    <= pidx_d;
      started_q <= started_d;
      first_q   <= first_d;
      digits_q  <= digits_d;
      pad_q     <= pad_d;
      didx_q    <= didx_d;
      gap_q     <= gap_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Every write state waits for gap_q to drain, then issues one strobe and reloads the gap.
  // first_q is the index of the leading significant digit; ERR mode forces it to 0 so the
  // same padding arithmetic yields 11 spaces before the five-letter error text.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    err_d     = err_q;
    neg_d     = neg_q;
    rem_d     = rem_q;
    cur_d     = cur_q;
    pidx_d    = pidx_q;
    started_d = started_q;
    first_d   = first_q;
    digits_d  = digits_q;
    pad_d     = pad_q;
    didx_d    = didx_q;
    gap_d     = gap_q;
    wr_d      = 1'b0;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          line_d    = LINE;
          err_d     = ERR;
          rem_d     = VALUE;
          neg_d     = 1'b0;
          cur_d     = 4'd0;
          pidx_d    = 3'd0;
          started_d = 1'b0;
          first_d   = 3'd0;
          didx_d    = 3'd0;
          gap_d     = 16'd0;
          busy_d    = 1'b1;
          state_d   = ERR ? CMD : ABS;
        end
      end
      ABS: begin
        neg_d   = rem_q[15];
        rem_d   = rem_q[15] ? (16'd0 - rem_q) : rem_q;
        state_d = CONV;
      end
      CONV: begin
        if (rem_q >= placeVal(pidx_q)) begin
          rem_d = rem_q - placeVal(pidx_q);
          cur_d = cur_q + 4'd1;
        end else begin
          digits_d[pidx_q] = cur_q;
          cur_d            = 4'd0;
          if (!started_q && (cur_q != 4'd0 || pidx_q == 3'd4)) begin
            started_d = 1'b1;
            first_d   = pidx_q;
          end
          if (pidx_q == 3'd4) state_d = CMD;
          else                pidx_d  = pidx_q + 3'd1;
        end
      end
      CMD: begin
        if (gap_q != 16'd0) gap_d = gap_q - 16'd1;
        else begin
          wr_d    = 1'b1;
          data_d  = {1'b0, line_q ? 8'hC0 : 8'h80};
          gap_d   = GAP;
          pad_d   = 4'd11 + {1'b0, first_q} - {3'b000, neg_q};
          state_d = PAD;
        end
      end
      PAD: begin
        if (gap_q != 16'd0) gap_d = gap_q - 16'd1;
        else begin
          wr_d   = 1'b1;
          data_d = 9'h120;
          gap_d  = GAP;
          pad_d  = pad_q - 4'd1;
          if (pad_q == 4'd1) begin
            didx_d  = first_q;
            state_d = neg_q ? SIGN : DIGIT;
          end
        end
      end
      SIGN: begin
        if (gap_q != 16'd0) gap_d = gap_q - 16'd1;
        else begin
          wr_d    = 1'b1;
          data_d  = 9'h12D;
          gap_d   = GAP;
          state_d = DIGIT;
        end
      end
      DIGIT: begin
        if (gap_q != 16'd0) gap_d = gap_q - 16'd1;
        else begin
          wr_d   = 1'b1;
          data_d = err_q ? {1'b1, errChar(didx_q)} : {1'b1, 4'h3, digits_q[didx_q]};
          gap_d  = GAP;
          if (didx_q == 3'd4) state_d = FIN;
          else                didx_d  = didx_q + 3'd1;
        end
      end
      FIN: begin
        if (gap_q != 16'd0) gap_d = gap_q - 16'd1;
        else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign WR_EN    = wr_q;
  assign DATA_OUT = data_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_lcd_result_writer.sv
// Scoreboard bench for lcd_result_writer: two instances (gap 0 and gap 3) share the data
// inputs; expected FIFO entries are derived from the decimal text of each value.
module tb_lcd_result_writer;

  logic        clk = 1'b0;
  logic        rst, start0, start3, lineIn, errIn;
  logic [15:0] valueIn;
  logic        wr0, busy0, done0, wr3, busy3, done3;
  logic [8:0]  data0, data3;

  logic [8:0]  exp0[$];
  logic [8:0]  exp3[$];
  logic [8:0]  e0, e3;
  int errors = 0, checks = 0, cyc = 0;
  int wrCount0 = 0, wrCount3 = 0, lastWr0 = 0, lastWr3 = 0;
  int doneCount0 = 0, doneCount3 = 0, doneCyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_result_writer #(.GAP_CYCLES(0)) u0 (
    .clk(clk), .RST(rst), .START(start0), .VALUE(valueIn), .LINE(lineIn), .ERR(errIn),
    .WR_EN(wr0), .DATA_OUT(data0), .BUSY(busy0), .DONE(done0)
  );

  lcd_result_writer #(.GAP_CYCLES(3)) u3 (
    .clk(clk), .RST(rst), .START(start3), .VALUE(valueIn), .LINE(lineIn), .ERR(errIn),
    .WR_EN(wr3), .DATA_OUT(data3), .BUSY(busy3), .DONE(done3)
  );

  // Pop and compare every FIFO write; the gap-3 instance also has its write spacing checked.
  always @(negedge clk) begin
    if (wr0) begin
      checks++;
      if (exp0.size() == 0) begin
        errors++;
        $display("[TB] FAIL u0_unexpected_write: got %h, required no write", data0);
      end else begin
        e0 = exp0.pop_front();
        if (data0 !== e0) begin
          errors++;
          $display("[TB] FAIL u0_data write %0d: got %h, required %h", wrCount0, data0, e0);
        end
      end
      lastWr0 = cyc;
      wrCount0++;
    end
    if (done0) doneCount0++;
    if (wr3) begin
      checks++;
      if (exp3.size() == 0) begin
        errors++;
        $display("[TB] FAIL u3_unexpected_write: got %h, required no write", data3);
      end else begin
        e3 = exp3.pop_front();
        if (data3 !== e3) begin
          errors++;
          $display("[TB] FAIL u3_data write %0d: got %h, required %h", wrCount3, data3, e3);
        end
      end
      if (wrCount3 > 0) begin
        checks++;
        if (cyc - lastWr3 != 4) begin
          errors++;
          $display("[TB] FAIL u3_spacing: got %0d clocks, required 4", cyc - lastWr3);
        end
      end
      lastWr3 = cyc;
      wrCount3++;
    end
    if (done3) doneCount3++;
  end

  task automatic pushFrame(input bit toU3, input logic signed [15:0] v, input bit ln,
                           input bit er, input int keep);
    string s;
    int mag;
    logic [8:0] f[$];
    f.push_back(ln ? 9'h0C0 : 9'h080);
    if (er) s = "ERROR";
    else begin
      mag = int'(v);
      if (mag < 0) s = $sformatf("-%0d", -mag);
      else         s = $sformatf("%0d", mag);
    end
    for (int i = 0; i < 16 - s.len(); i++) f.push_back(9'h120);
    for (int i = 0; i < s.len(); i++) f.push_back({1'b1, s[i]});
    for (int i = 0; i < keep && i < f.size(); i++) begin
      if (toU3) exp3.push_back(f[i]);
      else      exp0.push_back(f[i]);
    end
  endtask

  task automatic pulseStart(input bit toU3, input logic [15:0] v, input bit ln, input bit er);
    @(negedge clk);
    valueIn = v;
    lineIn  = ln;
    errIn   = er;
    if (toU3) start3 = 1'b1;
    else      start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic waitDone(input bit toU3, input int limit);
    int n = 0;
    while (n < limit) begin
      @(negedge clk);
      if (toU3 ? done3 : done0) break;
      n++;
    end
    doneCyc = cyc;
    checks++;
    if (n >= limit) begin
      errors++;
      $display("[TB] FAIL done_timeout: got no DONE in %0d clocks, required DONE", limit);
    end else if ((toU3 ? busy3 : busy0) !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_at_done: got 1, required 0");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr0, data0, busy0, done0} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_u0: got wr=%b data=%h busy=%b done=%b, required all 0",
               wr0, data0, busy0, done0);
    end
    checks++;
    if ({wr3, data3, busy3, done3} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_u3: got wr=%b data=%h busy=%b done=%b, required all 0",
               wr3, data3, busy3, done3);
    end
    rst = 1'b0;
  endtask

  task automatic test_frame0(input logic [15:0] v, input bit ln, input bit er, input string name);
    wrCount0 = 0;
    doneCount0 = 0;
    pushFrame(1'b0, v, ln, er, 17);
    pulseStart(1'b0, v, ln, er);
    waitDone(1'b0, 500);
    checks++;
    if (wrCount0 != 17) begin
      errors++;
      $display("[TB] FAIL %s_count: got %0d writes, required 17", name, wrCount0);
    end
    checks++;
    if (doneCyc - lastWr0 != 1) begin
      errors++;
      $display("[TB] FAIL %s_done_delay: got %0d, required 1", name, doneCyc - lastWr0);
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || doneCount0 != 1 || exp0.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_done_pulse: got done=%b count=%0d left=%0d, required 0/1/0",
               name, done0, doneCount0, exp0.size());
    end
  endtask

  task automatic test_gap();
    wrCount3 = 0;
    pushFrame(1'b1, 16'd12345, 1'b0, 1'b0, 17);
    pulseStart(1'b1, 16'd12345, 1'b0, 1'b0);
    waitDone(1'b1, 800);
    checks++;
    if (wrCount3 != 17 || exp3.size() != 0) begin
      errors++;
      $display("[TB] FAIL gap_count: got %0d writes (%0d left), required 17 (0)",
               wrCount3, exp3.size());
    end
    checks++;
    if (doneCyc - lastWr3 != 4) begin
      errors++;
      $display("[TB] FAIL gap_done_delay: got %0d, required 4", doneCyc - lastWr3);
    end
  endtask

  task automatic test_err();
    wrCount0 = 0;
    pushFrame(1'b0, 16'h1234, 1'b0, 1'b1, 17);
    pulseStart(1'b0, 16'h1234, 1'b0, 1'b1);
    checks++;
    if (busy0 !== 1'b1 || wr0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_busy_rise: got busy=%b wr=%b, required 1/0", busy0, wr0);
    end
    @(negedge clk);
    checks++;
    if (wr0 !== 1'b1 || data0 !== 9'h080) begin
      errors++;
      $display("[TB] FAIL err_first_write: got wr=%b data=%h, required 1/080", wr0, data0);
    end
    waitDone(1'b0, 500);
    checks++;
    if (wrCount0 != 17 || exp0.size() != 0) begin
      errors++;
      $display("[TB] FAIL err_count: got %0d writes, required 17", wrCount0);
    end
  endtask

  task automatic test_back_to_back();
    wrCount0 = 0;
    doneCount0 = 0;
    pushFrame(1'b0, 16'd42, 1'b0, 1'b0, 17);
    pulseStart(1'b0, 16'd42, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    pulseStart(1'b0, 16'd999, 1'b1, 1'b0);
    waitDone(1'b0, 500);
    pushFrame(1'b0, 16'd5, 1'b1, 1'b0, 17);
    pulseStart(1'b0, 16'd5, 1'b1, 1'b0);
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_restart: got busy=%b, required 1", busy0);
    end
    waitDone(1'b0, 500);
    checks++;
    if (wrCount0 != 34 || doneCount0 != 2 || exp0.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d writes %0d dones, required 34 writes 2 dones",
               wrCount0, doneCount0);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    wrCount0 = 0;
    pushFrame(1'b0, 16'd321, 1'b0, 1'b0, 5);
    pulseStart(1'b0, 16'd321, 1'b0, 1'b0);
    while (n < 500 && wrCount0 < 5) begin
      @(negedge clk);
      #1;
      n++;
    end
    rst = 1'b1;
    checks++;
    if (n >= 500) begin
      errors++;
      $display("[TB] FAIL midreset_wait: got %0d writes, required 5", wrCount0);
    end
    @(negedge clk);
    checks++;
    if (wr0 !== 1'b0 || data0 !== 9'h000 || busy0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got wr=%b data=%h busy=%b, required 0/000/0",
               wr0, data0, busy0);
    end
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (wrCount0 != 5 || exp0.size() != 0) begin
      errors++;
      $display("[TB] FAIL midreset_silent: got %0d writes, required 5", wrCount0);
    end
    test_frame0(16'd7, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0;
    start3 = 1'b0;
    lineIn = 1'b0;
    errIn = 1'b0;
    valueIn = 16'd0;
    test_reset();
    test_frame0(16'd0, 1'b0, 1'b0, "zero");
    test_frame0(16'h8000, 1'b1, 1'b0, "min");
    test_frame0(16'd9, 1'b1, 1'b0, "nine");
    test_frame0(16'hFFFF, 1'b0, 1'b0, "minus_one");
    test_gap();
    test_err();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
